// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity mode selectors for the PARITY parameter
//   rx_state_e                : receiver FSM state encoding
//   majority3                 : 2-of-3 vote used for mid-bit sampling
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line plus falling-edge detect.
//   clk, rst_n : clock, asynchronous active-low reset (all flops reset to 1 = idle line)
//   rx_i       : raw asynchronous serial input
//   rx_s_o     : synchronized line value
//   fall_o     : high for one cycle when rx_s_o goes 1 -> 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..8 data bits, none/even/odd parity,
// 1 or 2 stop bits) with a held output word and sticky overrun.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx          : serial line, idle high, LSB first
//   data_ready  : consumer accepts the held word when high with data_valid
//   data_out    : received word
//   data_valid  : data_out and error flags valid, held until accepted
//   parity_err  : parity mismatch on the held word
//   frame_err   : a stop bit sampled low on the held word
//   overrun     : sticky, a frame completed while a word was still held
//   busy        : receiver not in IDLE
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_S0    = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] CNT_S1    = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] CNT_DEC   = 16'(CLKS_PER_BIT / 2 + 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    rx_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;

    logic [DATA_BITS-1:0] data_out_q;
    logic                 valid_q, par_out_q, frm_out_q, ovr_q;

    logic wrap;
    logic decide;
    logic bit_v;
    logic par_x;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;

        wrap   = (cnt_q == CNT_LAST);
        decide = (cnt_q == CNT_DEC);
        bit_v  = majority3(samp_q[0], samp_q[1], rx_s);
        par_x  = (^shift_q) ^ bit_v;

        if (state_q != ST_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 16'd1;
            if (cnt_q == CNT_S0) samp_d[0] = rx_s;
            if (cnt_q == CNT_S1) samp_d[1] = rx_s;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (decide && bit_v) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) shift_d = {bit_v, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) perr_d = (PARITY == PAR_ODD) ? ~par_x : par_x;
                if (wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (decide) begin
                    if (!bit_v) ferr_d = 1'b1;
                    // Last stop bit: leave at the decision point so a
                    // back-to-back start edge is not missed.
                    if (stop_idx_q == LAST_STOP) begin
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                        stop_idx_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
        end
    end

    // Completion coinciding with acceptance reloads instead of flagging overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
            par_out_q  <= 1'b0;
            frm_out_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else if (done_q) begin
            if (!valid_q || data_ready) begin
                data_out_q <= shift_q;
                par_out_q  <= perr_q;
                frm_out_q  <= ferr_q;
                valid_q    <= 1'b1;
            end else begin
                ovr_q <= 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = par_out_q;
    assign frame_err  = frm_out_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: instance A is 8N1, instance B is 7E1.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx_a, rx_b, ready_a, ready_b;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_ready(ready_a),
        .data_out(dout_a), .data_valid(valid_a), .parity_err(perr_a),
        .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_ready(ready_b),
        .data_out(dout_b), .data_valid(valid_b), .parity_err(perr_b),
        .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } chk_t;

    exp_t qa[$];
    exp_t qb[$];
    chk_t qc[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Point checks from the stimulus process are queued and judged by the monitor.
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.want = want;
        qc.push_back(c);
    endtask

    task automatic expect_a(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
        qa.push_back(e);
    endtask

    task automatic expect_b(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
        qb.push_back(e);
    endtask

    // bits[0] is the start bit; 10 bit periods, then line returns high.
    task automatic send_bits(input bit to_b, input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            if (to_b) rx_b = bits[i]; else rx_a = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (to_b) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    // Monitor: every accepted word is compared against the scoreboard head.
    always @(negedge clk) begin
        chk_t c;
        exp_t e;
        while (qc.size() > 0) begin
            c = qc.pop_front();
            n_checks++;
            if (c.got !== c.want) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, c.got, c.want);
            end
        end
        if (valid_a && ready_a) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_word: got data=0x%0h, expected no word", dout_a);
            end else begin
                e = qa.pop_front();
                if ({dout_a, perr_a, ferr_a, ovr_a} !== {e.data, e.perr, e.ferr, e.ovr}) begin
                    n_fail++;
                    $display("FAIL a_word: got data=0x%0h perr=%0b ferr=%0b ovr=%0b, expected data=0x%0h perr=%0b ferr=%0b ovr=%0b",
                             dout_a, perr_a, ferr_a, ovr_a, e.data, e.perr, e.ferr, e.ovr);
                end
            end
        end
        if (valid_b && ready_b) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_word: got data=0x%0h, expected no word", dout_b);
            end else begin
                e = qb.pop_front();
                if ({1'b0, dout_b, perr_b, ferr_b, ovr_b} !== {e.data, e.perr, e.ferr, e.ovr}) begin
                    n_fail++;
                    $display("FAIL b_word: got data=0x%0h perr=%0b ferr=%0b ovr=%0b, expected data=0x%0h perr=%0b ferr=%0b ovr=%0b",
                             dout_b, perr_b, ferr_b, ovr_b, e.data, e.perr, e.ferr, e.ovr);
                end
            end
        end
    end

    initial begin
        int k;
        rst_n   = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        #22;
        check("rst_data_out", 32'(dout_a), 32'h0);
        check("rst_valid",    32'(valid_a), 32'h0);
        check("rst_perr",     32'(perr_a), 32'h0);
        check("rst_ferr",     32'(ferr_a), 32'h0);
        check("rst_overrun",  32'(ovr_a), 32'h0);
        check("rst_busy",     32'(busy_a), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 0xA5, consumer ready
        expect_a(8'hA5, 1'b0, 1'b0, 1'b0);
        send_bits(1'b0, {1'b1, 8'hA5, 1'b0});
        repeat (4) @(posedge clk);
        #1;
        check("a5_valid_cleared", 32'(valid_a), 32'h0);

        // Short low glitch must be rejected
        rx_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_a = 1'b1;
        check("glitch_busy_rose", 32'(busy_a), 32'h1);
        k = 0;
        while (busy_a && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("glitch_busy_dropped", 32'(busy_a), 32'h0);
        repeat (CPB * 2) @(posedge clk);
        #1;
        check("glitch_no_valid", 32'(valid_a), 32'h0);

        // Stop bit low: framing error, data still delivered; next frame clean
        expect_a(8'h3C, 1'b0, 1'b1, 1'b0);
        send_bits(1'b0, {1'b0, 8'h3C, 1'b0});
        repeat (CPB) @(posedge clk);
        #1;
        expect_a(8'h55, 1'b0, 1'b0, 1'b0);
        send_bits(1'b0, {1'b1, 8'h55, 1'b0});
        repeat (4) @(posedge clk);
        #1;

        // Overrun: two frames with consumer stalled
        ready_a = 1'b0;
        expect_a(8'h11, 1'b0, 1'b0, 1'b1);
        send_bits(1'b0, {1'b1, 8'h11, 1'b0});
        send_bits(1'b0, {1'b1, 8'h22, 1'b0});
        repeat (CPB) @(posedge clk);
        #1;
        check("ovr_valid_held", 32'(valid_a), 32'h1);
        check("ovr_data_held",  32'(dout_a), 32'h11);
        check("ovr_flag",       32'(ovr_a), 32'h1);
        ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovr_valid_cleared", 32'(valid_a), 32'h0);
        check("ovr_sticky",        32'(ovr_a), 32'h1);

        // Reset during bit 4 of 0xFF
        rx_a = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (CPB * 4 + CPB / 2) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_data_out", 32'(dout_a), 32'h0);
        check("midrst_valid",    32'(valid_a), 32'h0);
        check("midrst_perr",     32'(perr_a), 32'h0);
        check("midrst_ferr",     32'(ferr_a), 32'h0);
        check("midrst_overrun",  32'(ovr_a), 32'h0);
        check("midrst_busy",     32'(busy_a), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy_a), 32'h0);
        expect_a(8'h81, 1'b0, 1'b0, 1'b0);
        send_bits(1'b0, {1'b1, 8'h81, 1'b0});
        repeat (4) @(posedge clk);
        #1;

        // 7E1: 0x41 has two ones, so even parity bit is 0
        expect_b(8'h41, 1'b1, 1'b0, 1'b0);
        send_bits(1'b1, {1'b1, 1'b1, 7'h41, 1'b0});
        repeat (4) @(posedge clk);
        #1;
        expect_b(8'h41, 1'b0, 1'b0, 1'b0);
        send_bits(1'b1, {1'b1, 1'b0, 7'h41, 1'b0});
        repeat (CPB) @(posedge clk);
        #1;

        check("a_scoreboard_drained", 32'(qa.size()), 32'h0);
        check("b_scoreboard_drained", 32'(qb.size()), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per bit (434 = 50 MHz / 115200); legal 16..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal 5..8.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked; legal 1 or 2.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rx  in  1  asynchronous serial line, idle high, LSB first.
REQ-008 data_ready  in  1  consumer accepts data_out when high with data_valid.
REQ-009 data_out  out  DATA_BITS  received word.
REQ-010 data_valid  out  1  data_out/error flags valid; held until accepted.
REQ-011 parity_err  out  1  parity mismatch on the held word.
REQ-012 frame_err  out  1  a stop bit was sampled low on the held word.
REQ-013 overrun  out  1  sticky; a frame completed while data_valid was high.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s and its previous value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-017 IDLE -> START on rx_s falling edge (previous 1, current 0); baud counter cleared to 0.
REQ-018 Baud counter SHALL run 0..CLKS_PER_BIT-1 and wrap; HALF = CLKS_PER_BIT/2 (integer division).
REQ-019 Each bit value SHALL be the majority of rx_s at counts HALF-1, HALF, HALF+1; the decision is made at count HALF+1.
REQ-020 START: majority 1 at decision -> IDLE, no output (glitch reject); majority 0 -> DATA at next counter wrap.
REQ-021 DATA: shift DATA_BITS samples LSB first; 3-bit bit index wraps to 0 on leaving DATA.
REQ-022 PARITY: even mode expects XOR(data, parity bit) = 0, odd mode expects 1; a mismatch flags the frame.
REQ-023 STOP: each of STOP_BITS samples checked; any low sample flags the frame; after the last stop-bit decision, return to IDLE immediately, without waiting for the end of the bit period.
REQ-024 Frame completion SHALL occur one cycle after the last stop-bit decision, when data_valid is low: load data_out, parity_err and frame_err, set data_valid.
REQ-025 data_valid && data_ready clears data_valid on the next edge; data_out and the error flags hold their values.
REQ-026 Completion while data_valid is high: set overrun; drop the new word; data_out, data_valid and the error flags are unchanged.
REQ-027 Completion in the same cycle as an acceptance of the old word is not an overrun: load the new word, data_valid stays 1.
REQ-028 overrun clears only on reset.
REQ-029 A frame with frame_err SHALL still deliver data; a following start requires rx_s to return high first.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE; counters 0; shift register 0; synchronizer flops 1.
REQ-031 Outputs during reset: data_out 0; data_valid, parity_err, frame_err, overrun and busy all 0.
REQ-032 Reset mid-frame SHALL abort the frame with no output; after release, reception needs a new falling edge.

Structure
REQ-033 Shared package uart_pkg SHALL hold the parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state encoding.
REQ-034 One sub-module, uart_rx_sync, SHALL implement the 2-flop synchronizer plus falling-edge detect; all other logic is in uart_rx_cfg.

Verification (bench CLKS_PER_BIT=16, rx driven 16 cycles/bit)
REQ-035 8N1, send 0xA5, data_ready=1 -> data_out=0xA5, data_valid one cycle, parity_err=frame_err=overrun=0.
REQ-036 rx low for 4 cycles, then high -> no data_valid, busy drops within 10 cycles, FSM in IDLE.
REQ-037 DATA_BITS=7, PARITY=1, send 0x41 with parity bit 1 -> data_out=0x41, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-038 8N1, send 0x3C with stop bit 0 -> data_out=0x3C, frame_err=1; next 0x55 frame after line high -> 0x55, frame_err=0.
REQ-039 data_ready=0, send 0x11 then 0x22 back-to-back -> data_out=0x11, overrun=1; set data_ready=1 -> data_valid clears, overrun stays 1.
REQ-040 Assert rst_n low during bit 4 of 0xFF -> all outputs 0 immediately; after release, send 0x81 -> data_out=0x81, no errors.
